encrypter_core: RTL and testbench

Single encryption lane sitting directly downstream of the parallelizer. It is instantiated `NUM_ENCRYPTERS` times and shares the broadcast data/key-rotation bus. It accepts a key on `program` and a plaintext packet plus rotation amount on `data_ready`, and runs a fixed multi-cycle rotate/XOR mix. It presents the ciphertext on a valid/ack output handshake and raises `ready` only when it can take a new packet.

---
 rtl/encrypter_core.sv | 131 +++++++++++++
 tb/tb_encrypter_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/encrypter_core.sv
// Single encryption lane: key load, rotated-key derivation, ROUNDS rotate/XOR mix, valid/ack output.
// Optional ENCRYPTER_TAG_EN adds out_tag_o, the rotation value latched with the packet.
module encrypter_core #(
  parameter int WIDTH     = 32,
  parameter int ROT_WIDTH = 5,
  parameter int ROUNDS    = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [ROT_WIDTH-1:0] key_rotation_i,
  input  logic                 program_i,
  input  logic                 data_ready_i,
  output logic                 ready_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ack_i
`ifdef ENCRYPTER_TAG_EN
  ,
  output logic [ROT_WIDTH-1:0] out_tag_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_KEYROT = 3'd2,
    S_ROUND  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       key_q, key_d;
  logic [WIDTH-1:0]       d_q, d_d;
  logic [WIDTH-1:0]       rk_q, rk_d;
  logic [ROT_WIDTH-1:0]   rot_q, rot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ready_q, ready_d;

  // Carry-free left rotation; the doubled word makes a zero shift come out as the identity.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned sh);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} << (sh % WIDTH);
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    d_d        = d_q;
    rk_d       = rk_q;
    rot_d      = rot_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (program_i) begin
          key_d   = data_i;
          state_d = S_READY;
        end
      end
      S_READY: begin
        // program takes priority; a coincident packet is dropped
        if (program_i) begin
          key_d = data_i;
        end else if (data_ready_i) begin
          d_d     = data_i;
          rot_d   = key_rotation_i;
          state_d = S_KEYROT;
        end
      end
      S_KEYROT: begin
        rk_d    = rotl(key_q, 32'(rot_q));
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        d_d   = rotl(d_q ^ rk_q, 1);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_RND) begin
          out_data_d = d_d;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ack_i) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d     = (state_d == S_READY);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      d_q         <= '0;
      rk_q        <= '0;
      rot_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      d_q         <= d_d;
      rk_q        <= rk_d;
      rot_q       <= rot_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o     = ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
`ifdef ENCRYPTER_TAG_EN
  // rot_q is only rewritten on the next accept, so it stays stable while out_valid_o is high
  assign out_tag_o = rot_q;
`endif

endmodule

// File: tb/tb_encrypter_core.sv
// Directed bench for encrypter_core: vector table of key/packet/rotation cases plus hand-written
// sequences for backpressure, collisions, the unprogrammed lane and mid-operation reset.
module tb_encrypter_core;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] data_i;
  logic [4:0]  key_rotation_i;
  logic        program_i;
  logic        data_ready_i;
  logic        ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ack_i;
`ifdef ENCRYPTER_TAG_EN
  logic [4:0]  out_tag_o;
`endif

  int checks = 0;
  int errors = 0;

  encrypter_core #(.WIDTH(32), .ROT_WIDTH(5), .ROUNDS(2)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .data_i         (data_i),
    .key_rotation_i (key_rotation_i),
    .program_i      (program_i),
    .data_ready_i   (data_ready_i),
    .ready_o        (ready_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ack_i      (out_ack_i)
`ifdef ENCRYPTER_TAG_EN
    ,
    .out_tag_o      (out_tag_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] key;
    logic [31:0] data;
    logic [4:0]  rot;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic prog(input logic [31:0] key);
    program_i = 1'b1;
    data_i    = key;
    step();
    program_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] rot);
    data_ready_i   = 1'b1;
    data_i         = d;
    key_rotation_i = rot;
    step();
    data_ready_i = 1'b0;
  endtask

  // Called right after send(): counts edges until out_valid_o, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic do_ack();
    out_ack_i = 1'b1;
    step();
    out_ack_i = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    vecs[0] = '{key: 32'h000000FF, data: 32'h00000000, rot: 5'd4,  exp: 32'h00002020};
    vecs[1] = '{key: 32'h80000001, data: 32'h00000000, rot: 5'd0,  exp: 32'h00000005};
    vecs[2] = '{key: 32'h00000001, data: 32'h00000000, rot: 5'd31, exp: 32'h00000003};
    vecs[3] = '{key: 32'h12345678, data: 32'hA5A5A5A5, rot: 5'd8,  exp: 32'h2F6386FA};

    reset_i = 1'b0; data_i = '0; key_rotation_i = '0;
    program_i = 1'b0; data_ready_i = 1'b0; out_ack_i = 1'b0;
    #1 reset_i = 1'b1;
    #2;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_data", out_data_o, 32'd0);
`ifdef ENCRYPTER_TAG_EN
    chk("rst_tag", {27'd0, out_tag_o}, 32'd0);
`endif
    step();
    reset_i = 1'b0;
    step();

    // unprogrammed lane ignores packets
    send(32'h12345678, 5'd3);
    for (int i = 0; i < 5; i++) begin
      chk("idle_ready", {31'd0, ready_o}, 32'd0);
      chk("idle_valid", {31'd0, out_valid_o}, 32'd0);
      step();
    end

    for (int v = 0; v < 4; v++) begin
      prog(vecs[v].key);
      chk("prog_ready", {31'd0, ready_o}, 32'd1);
      send(vecs[v].data, vecs[v].rot);
      chk("ready_drop", {31'd0, ready_o}, 32'd0);
      wait_out(lat);
      chk("latency", lat, 32'd3);
      chk("out_data", out_data_o, vecs[v].exp);
`ifdef ENCRYPTER_TAG_EN
      chk("out_tag", {27'd0, out_tag_o}, {27'd0, vecs[v].rot});
`endif
      do_ack();
      chk("ack_valid", {31'd0, out_valid_o}, 32'd0);
      chk("ack_ready", {31'd0, ready_o}, 32'd1);
    end

    // backpressure: output held, stray packet ignored
    prog(32'h000000FF);
    send(32'h00000000, 5'd4);
    wait_out(lat);
    chk("bp_latency", lat, 32'd3);
    held = out_data_o;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_data", out_data_o, 32'h00002020);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      data_ready_i = (i == 4);
      program_i    = (i == 6);
      data_i       = (i == 6) ? 32'h0F0F0F0F : 32'hDEADBEEF;
      key_rotation_i = 5'd7;
      step();
    end
    data_ready_i = 1'b0;
    program_i    = 1'b0;
    chk("bp_held", out_data_o, held);
    do_ack();
    chk("bp_ack_ready", {31'd0, ready_o}, 32'd1);
    chk("bp_ack_valid", {31'd0, out_valid_o}, 32'd0);
    do_ack();
    chk("stray_ack_ready", {31'd0, ready_o}, 32'd1);
    chk("stray_ack_valid", {31'd0, out_valid_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_extra", {31'd0, out_valid_o}, 32'd0);
      step();
    end
    // key must still be 0xFF despite the program pulse during OUT
    send(32'h00000000, 5'd4);
    wait_out(lat);
    chk("bp_key_kept", out_data_o, 32'h00002020);
    do_ack();

    // collision in READY: program wins, packet dropped, new key in effect
    program_i      = 1'b1;
    data_ready_i   = 1'b1;
    data_i         = 32'h80000001;
    key_rotation_i = 5'd0;
    step();
    program_i    = 1'b0;
    data_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("col_ready", {31'd0, ready_o}, 32'd1);
      chk("col_valid", {31'd0, out_valid_o}, 32'd0);
      step();
    end
    send(32'h00000000, 5'd0);
    wait_out(lat);
    chk("col_latency", lat, 32'd3);
    chk("col_newkey", out_data_o, 32'h00000005);
    do_ack();

    // asynchronous reset during ROUND
    prog(32'h000000FF);
    send(32'h00000000, 5'd4);
    step();
    #3 reset_i = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_data", out_data_o, 32'd0);
    step();
    reset_i = 1'b0;
    send(32'h00000000, 5'd0);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("post_rst_ready", {31'd0, ready_o}, 32'd0);
      step();
    end
    prog(32'h00000001);
    chk("reprog_ready", {31'd0, ready_o}, 32'd1);
    send(32'h00000000, 5'd31);
    wait_out(lat);
    chk("reprog_data", out_data_o, 32'h00000003);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
